muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in data width and multiply radix. It replaces the single-cycle HI/LO arithmetic in the execute stage. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start strobe and stalls on `busy`. MFHI/MFLO read the `HI`/`LO` outputs directly.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 8.
- `MUL_BITS`, 1: multiplier bits retired per multiply iteration; one of 1, 2, 4; must divide `WIDTH`.
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: reset. One clock; reset is asynchronous and active-high.
- `start`  in  1: issue strobe, sampled on the rising edge.
- `op`  in  3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `Rdata1`  in  WIDTH: rs; multiplicand or dividend; source for MTHI/MTLO.
- `Rdata2`  in  WIDTH: rt; multiplier or divisor.
- `busy`  out  1: an operation is in progress; new starts are ignored.
- `done`  out  1: one-cycle pulse; HI/LO were updated by MULT/MULTU/DIV/DIVU on the preceding edge.
- `div_zero`  out  1: last DIV/DIVU had a zero divisor; holds until the next accepted start.
- `HI`  out  WIDTH: HI register.
- `LO`  out  WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: state=IDLE, `HI`=0, `LO`=0, `busy`=0, `done`=0, `div_zero`=0, iteration counter=0.
- A start is accepted only when `start`=1 in IDLE (`busy`=0). A start while busy is dropped with no side effects, including MTHI/MTLO.
- Acceptance latches the operands, clears `div_zero` and sets `busy`.
- MTHI/MTLO: `HI`/`LO` ← `Rdata1` on the accepting edge. State stays IDLE; no `busy`, no `done`.
- Signed ops (MULT, DIV):
  - Operand magnitudes are latched at acceptance.
  - Result and remainder sign flags are latched at acceptance.
  - Sign correction is applied in FIX.
- MUL state:
  - Shift-add on a 2·WIDTH accumulator, `MUL_BITS` multiplier bits per cycle.
  - Runs for WIDTH/`MUL_BITS` iterations, then goes to FIX.
- DIV state:
  - Restoring division, one quotient bit per cycle.
  - Runs for WIDTH iterations, then goes to FIX.
- Divisor zero at acceptance: go straight to FIX (zero iterations) and set `div_zero`=1.
  - Result: `LO`=all ones, `HI`=`Rdata1` as issued (unsigned and signed alike).
- FIX:
  - Applies two's-complement negation where required.
  - Writes `HI` (product upper half / remainder) and `LO` (product lower half / quotient).
  - Returns to IDLE, clears `busy`, sets `done` for one cycle.
- Arithmetic rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MULT gives the full 2·WIDTH signed product; MULTU gives the unsigned product.
  - Signed overflow (most-negative / −1) wraps: `LO`=most-negative, `HI`=0.
- `HI`/`LO` hold their old values for the whole busy period. No partial results are visible.

## Timing
- Accepting edge E0. Iteration edges E1..En, FIX edge En+1.
  - n = WIDTH/`MUL_BITS` for multiply.
  - n = WIDTH for divide.
  - n = 0 for divide-by-zero.
- `busy` is high from after E0 until after En+1, i.e. n+1 cycles.
- `HI`/`LO` update on En+1. `done` is high for the single cycle after En+1, which is also the first cycle with `busy`=0.
- A new start may be accepted on the edge that ends the `done` cycle. Back-to-back ops have no dead cycle beyond `done`.
- `RST` asserted at any time, including mid-operation: the operation is aborted and all outputs take their reset values immediately, without waiting for `CLK`.
- An operation in flight when `RST` falls does not resume; the unit waits in IDLE.

## Test plan
- MULT `Rdata1`=FFFFFFFD, `Rdata2`=00000007 (WIDTH=32, `MUL_BITS`=1) -> `busy` for 33 cycles, then `HI`=FFFFFFFF, `LO`=FFFFFFEB with a one-cycle `done`.
- MULTU FFFFFFFF × FFFFFFFF -> `HI`=FFFFFFFE, `LO`=00000001. Repeat with `MUL_BITS`=4: `busy` for 9 cycles, same result.
- DIV −7 / 2 -> `LO`=FFFFFFFD, `HI`=FFFFFFFF after 33 busy cycles. DIV 80000000 / FFFFFFFF -> `LO`=80000000, `HI`=0.
- DIVU 00000064 / 0 -> `busy` for 1 cycle, then `LO`=FFFFFFFF, `HI`=00000064, `div_zero`=1. `div_zero` stays 1 until the next accepted start (MTLO included), which clears it.
- MTHI 12345678 in IDLE -> `HI`=12345678 next cycle, no `busy`/`done`. MTLO or MULT issued during a running DIV -> ignored; DIV result unchanged.
- `RST` pulsed mid-DIV (cycle 10) -> `HI`=`LO`=0, `busy`=`done`=0 immediately. A fresh DIVU 9/4 afterwards -> `LO`=2, `HI`=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
//
// Multiply is shift-add with MUL_BITS multiplier bits retired per cycle. Divide is
// restoring division with one quotient bit per cycle. Signed operations run on
// magnitudes, and sign correction is applied in a final FIX cycle. HI/LO change
// only in FIX or on MTHI/MTLO, so a partial result is never visible.
//
// WIDTH must be even and >= 8. MUL_BITS must be 1, 2 or 4 and must divide WIDTH.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   start    in   issue strobe; accepted only while idle
//   op       in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   Rdata1   in   rs: multiplicand, dividend, or MTHI/MTLO source
//   Rdata2   in   rt: multiplier or divisor
//   busy     out  an operation is in progress
//   done     out  one-cycle pulse after HI/LO are written by an arithmetic op
//   div_zero out  last divide had a zero divisor; cleared by the next accepted start
//   HI, LO   out  architectural HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam int unsigned NMul  = WIDTH / MUL_BITS;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic                 neg_q, neg_d;     // negate product / quotient in FIX
  logic                 rneg_q, rneg_d;   // negate remainder in FIX
  logic                 is_div_q, is_div_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand magnitudes and signs at issue time
  logic                 op_signed;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;

  always_comb begin
    op_signed = (op == OpMult) || (op == OpDiv);
    sign_a    = op_signed & Rdata1[WIDTH-1];
    sign_b    = op_signed & Rdata2[WIDTH-1];
    mag_a     = sign_a ? (~Rdata1 + 1'b1) : Rdata1;
    mag_b     = sign_b ? (~Rdata2 + 1'b1) : Rdata2;
  end

  // One shift-add multiply step
  logic [MUL_BITS-1:0]       mul_digit;
  logic [WIDTH+MUL_BITS-1:0] mul_pp;
  logic [WIDTH+MUL_BITS-1:0] mul_upper;
  logic [2*WIDTH-1:0]        mul_next;

  always_comb begin
    mul_digit = acc_q[MUL_BITS-1:0];
    mul_pp    = {{MUL_BITS{1'b0}}, opb_q} * {{WIDTH{1'b0}}, mul_digit};
    mul_upper = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mul_pp;
    mul_next  = {mul_upper, acc_q[WIDTH-1:MUL_BITS]};
  end

  // One restoring divide step: trial-subtract the divisor from {rem, next dividend bit}
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign-corrected results consumed by FIX
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              state_d  = StMul;
              busy_d   = 1'b1;
              dz_d     = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = CntW'(NMul);
              acc_d    = {{WIDTH{1'b0}}, mag_b};
              opb_d    = mag_a;
              neg_d    = sign_a ^ sign_b;
              rneg_d   = 1'b0;
            end
            OpDiv, OpDivu: begin
              busy_d   = 1'b1;
              is_div_d = 1'b1;
              if (Rdata2 == '0) begin
                // Skip iterations; FIX passes {HI=Rdata1, LO=all ones} through unmodified
                state_d = StFix;
                dz_d    = 1'b1;
                cnt_d   = '0;
                acc_d   = {Rdata1, {WIDTH{1'b1}}};
                opb_d   = '0;
                neg_d   = 1'b0;
                rneg_d  = 1'b0;
              end else begin
                state_d = StDiv;
                dz_d    = 1'b0;
                cnt_d   = CntW'(WIDTH);
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                opb_d   = mag_b;
                neg_d   = sign_a ^ sign_b;
                rneg_d  = sign_a;
              end
            end
            OpMthi: begin
              hi_d = Rdata1;
              dz_d = 1'b0;
            end
            OpMtlo: begin
              lo_d = Rdata1;
              dz_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
